// File: rtl/imem_mp_if.sv
// Fetch/response and program-load bundle shared by the instruction memory and its requesters.
interface imem_mp_if #(
  parameter int unsigned NUM_PORTS = 2
);
  logic [NUM_PORTS-1:0]    req_valid;
  logic [32*NUM_PORTS-1:0] req_addr;
  logic [NUM_PORTS-1:0]    req_ready;
  logic [NUM_PORTS-1:0]    rsp_valid;
  logic [31:0]             rsp_data;
  logic                    rsp_err;
  logic                    ld_en;
  logic [31:0]             ld_addr;
  logic [31:0]             ld_data;

  modport master (
    output req_valid, req_addr, ld_en, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/imem_mp.sv
// Multi-port instruction memory: round-robin fetch arbitration, fixed-latency read-on-accept responses.
// Optional macro IMEM_BOUNDS_CHECK_EN flags misaligned/out-of-range fetches and answers them with a NOP.
module imem_mp #(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  imem_mp_if.slave bus
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam int unsigned PTR_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CNT_W    = 4;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic {IDLE, WAIT} state_e;

  logic [31:0] memory [DEPTH_WORDS];

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PTR_W-1:0]       last_q, last_d;
  logic [PTR_W-1:0]       id_q, id_d;
  logic [31:0]            hold_q, hold_d;
  logic                   hold_err_q, hold_err_d;
  logic [NUM_PORTS-1:0]   rsp_valid_q, rsp_valid_d;
  logic [31:0]            rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;

  logic                   win_c, found_c, hs_c, err_c;
  logic [PTR_W-1:0]       gnt_id_c;
  logic [NUM_PORTS-1:0]   grant_c;
  logic [31:0]            sel_addr_c, rd_c;
  logic [IDX_W-1:0]       mem_idx_c;
  logic                   unused_bits;

  // Round-robin search starting after the last-granted port.
  always_comb begin
    found_c    = 1'b0;
    gnt_id_c   = last_q;
    sel_addr_c = '0;
    win_c      = !bus.ld_en && ((state_q == IDLE) || (cnt_q == '0));
    for (int i = 1; i <= int'(NUM_PORTS); i++) begin
      if (!found_c && bus.req_valid[PTR_W'((int'(last_q) + i) % int'(NUM_PORTS))]) begin
        found_c  = 1'b1;
        gnt_id_c = PTR_W'((int'(last_q) + i) % int'(NUM_PORTS));
      end
    end
    for (int q = 0; q < int'(NUM_PORTS); q++) begin
      grant_c[q] = win_c && found_c && (gnt_id_c == PTR_W'(q));
      if (gnt_id_c == PTR_W'(q)) sel_addr_c = bus.req_addr[32*q +: 32];
    end
    hs_c = win_c && found_c;
  end

  // Single port: the load address wins, and fetches are never accepted in load cycles.
  assign mem_idx_c = bus.ld_en ? bus.ld_addr[IDX_W+1:2] : sel_addr_c[IDX_W+1:2];
  assign rd_c      = memory[mem_idx_c];

`ifdef IMEM_BOUNDS_CHECK_EN
  assign err_c       = (sel_addr_c[1:0] != 2'b00) || (sel_addr_c >= 32'(4 * DEPTH_WORDS));
  assign unused_bits = ^{bus.ld_addr[31:IDX_W+2], bus.ld_addr[1:0]};
`else
  assign err_c       = 1'b0;
  assign unused_bits = ^{bus.ld_addr[31:IDX_W+2], bus.ld_addr[1:0],
                         sel_addr_c[31:IDX_W+2], sel_addr_c[1:0]};
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    id_d        = id_q;
    hold_d      = hold_q;
    hold_err_d  = hold_err_q;
    rsp_valid_d = '0;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;
    if (hs_c) begin
      state_d    = WAIT;
      cnt_d      = CNT_W'(LATENCY - 1);
      last_d     = gnt_id_c;
      id_d       = gnt_id_c;
      hold_d     = err_c ? NOP_WORD : rd_c;
      hold_err_d = err_c;
    end else if (state_q == WAIT) begin
      if (cnt_q == '0) state_d = IDLE;
      else             cnt_d   = cnt_q - CNT_W'(1);
    end
    // Outputs are registered so they line up with the response cycle itself.
    if ((state_d == WAIT) && (cnt_d == '0)) begin
      for (int q = 0; q < int'(NUM_PORTS); q++) rsp_valid_d[q] = (id_d == PTR_W'(q));
      rsp_data_d = hold_d;
      rsp_err_d  = hold_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= PTR_W'(NUM_PORTS - 1);
      id_q        <= '0;
      hold_q      <= '0;
      hold_err_q  <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      id_q        <= id_d;
      hold_q      <= hold_d;
      hold_err_q  <= hold_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Program load; contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.ld_en) memory[mem_idx_c] <= bus.ld_data;
  end

  assign bus.req_ready = grant_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/imem_mp.md
IMEM_MP -- requirements
Module: imem_mp

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of requesting core fetch ports.
REQ-002 Parameter DEPTH_WORDS, default 1024: number of 32-bit words stored; power of two, at least 4.
REQ-003 Parameter LATENCY, default 1: cycles from request acceptance to response; range 1-15.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  NUM_PORTS  per-port fetch request.
REQ-007 req_addr  input  32*NUM_PORTS  per-port byte address; port p occupies bits [32p+31:32p].
REQ-008 req_ready  output  NUM_PORTS  per-port grant.
REQ-009 rsp_valid  output  NUM_PORTS  per-port one-cycle response strobe.
REQ-010 rsp_data  output  32  instruction word for the port whose rsp_valid bit is high.
REQ-011 rsp_err  output  1  address error flag, qualified by rsp_valid.
REQ-012 ld_en  input  1  program-load write enable.
REQ-013 ld_addr  input  32  program-load byte address.
REQ-014 ld_data  input  32  program-load word.

Function
REQ-015 Storage is a single-ported array of DEPTH_WORDS x 32 bits, named memory and reachable hierarchically, so benches can $readmemh into it.
REQ-016 The engine has two states. IDLE: no transaction in flight. WAIT: one transaction in flight, with a down-counter cnt.
REQ-017 Accept window: the engine can accept when state==IDLE, or when state==WAIT and cnt==0 (the response cycle); ld_en is low in both cases.
REQ-018 Arbitration is round-robin. The search starts at the port after the last-granted port. Exactly one req_ready bit is high, and only for a port with req_valid high; all bits are low outside the accept window. req_ready is combinational.
REQ-019 A handshake (req_valid&req_ready) at edge t captures the port id and address, loads cnt=LATENCY-1, enters WAIT, and updates the last-granted pointer.
REQ-020 In WAIT with cnt>0, cnt decrements by one each cycle.
REQ-021 The response cycle is the cycle where state==WAIT and cnt==0. In it:
- rsp_valid[id] is high; all other rsp_valid bits are low;
- rsp_data and rsp_err are valid;
- at the next edge the engine returns to IDLE unless a new handshake occurs.
REQ-022 rsp_valid rises exactly LATENCY cycles after the accepting edge. Back-to-back throughput is one transaction per LATENCY cycles.
REQ-023 Outside the response cycle, rsp_valid is all zeros, rsp_data is 0, and rsp_err is 0.
REQ-024 When ld_en is high, memory[ld_addr>>2 mod DEPTH_WORDS] is written at the edge. That cycle blocks acceptance, but an in-flight counter keeps decrementing.
REQ-025 If a load is pending on the response cycle, the response is still delivered. rsp_data reflects the memory content sampled at acceptance (read-on-accept).
REQ-026 A request whose address equals a same-cycle ld_addr cannot occur, because acceptance is blocked during load cycles.

Reset
REQ-027 When rst_n is low at an edge:
- state goes to IDLE, cnt to 0;
- rsp_valid goes to 0, rsp_data to 0, rsp_err to 0;
- the last-granted pointer goes to NUM_PORTS-1, so port 0 has first priority.
REQ-028 Reset mid-transaction discards the in-flight request; no response is ever issued for it.
REQ-029 Memory contents are not altered by reset.

Configuration
REQ-030 Macro IMEM_BOUNDS_CHECK_EN controls address checking. When defined, a request is in error if either:
- addr[1:0] != 0, or
- addr >= 4*DEPTH_WORDS.
REQ-031 With IMEM_BOUNDS_CHECK_EN defined, an errored request responds with rsp_err=1 and rsp_data=32'h00000013 (NOP); memory is not read.
REQ-032 Without IMEM_BOUNDS_CHECK_EN, the word index is addr[log2(DEPTH_WORDS)+1:2] (wrap-around), addr[1:0] is ignored, and rsp_err is tied to 0.

Verification
REQ-033 LATENCY=1: load word 0 = 0x00A00093 via ld_en, then port0 requests addr 0. Required: req_ready[0]=1, rsp_valid=2'b01 with rsp_data=0x00A00093 exactly one cycle later.
REQ-034 LATENCY=3: both ports hold req_valid with addrs 0x4 and 0x8. Required: grants alternate port0, port1, port0; each response arrives 3 cycles after its grant; data matches memory.
REQ-035 ld_en high for 2 cycles while port1 requests. Required: req_ready=0 during the load cycles; grant on the first cycle after ld_en drops.
REQ-036 Reset asserted one cycle after acceptance (LATENCY=3). Required: no rsp_valid pulse; next grant after reset goes to port0.
REQ-037 IMEM_BOUNDS_CHECK_EN defined, DEPTH_WORDS=1024, requests to addr 0x1000 and 0x2. Required: rsp_err=1, rsp_data=0x00000013. Without the macro, addr 0x1000 returns word 0 with rsp_err=0.
